// File: rtl/bcd_display_scan.sv
// bcd_display_scan: latches BCD digits on converter done and time-multiplexes them onto a 4-digit 7-segment display
module bcd_display_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 4,
    parameter bit LZ_BLANK       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_UND,
    input  logic [3:0] in_DEC,
    input  logic [3:0] in_CEN,
    input  logic [3:0] in_K,
    input  logic       in_DONE,
    output logic [6:0] out_SEG,
    output logic [3:0] out_AN,
    output logic       out_FRAME
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_LIT = CW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] AN_OFF = {4{AN_ACTIVE_LOW}};
    logic [3:0][3:0] dig;
    logic            valid;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0]      cur;
    logic            zk, zc, zd, blank, lit, wrap;
    logic [6:0]      enc;
    logic [6:0]      seg_hi;
    logic [3:0]      an_hi;
    assign cur = dig[idx];
    assign zk = dig[3] == 4'd0;
    assign zc = dig[2] == 4'd0;
    assign zd = dig[1] == 4'd0;
    assign wrap = cnt == CNT_LAST;
    always_comb begin
        case (cur)
            4'd0: enc = 7'h3F;
            4'd1: enc = 7'h06;
            4'd2: enc = 7'h5B;
            4'd3: enc = 7'h4F;
            4'd4: enc = 7'h66;
            4'd5: enc = 7'h6D;
            4'd6: enc = 7'h7D;
            4'd7: enc = 7'h07;
            4'd8: enc = 7'h7F;
            4'd9: enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    end
    always_comb begin
        blank = idx == 2'd3 ? zk :
                idx == 2'd2 ? zk && zc :
                idx == 2'd1 ? zk && zc && zd : 1'b0;
        lit = valid && cnt >= CNT_LIT && !(LZ_BLANK && blank);
        seg_hi = lit ? enc : 7'h00;
        an_hi = lit ? 4'b0001 << idx : 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dig       <= '0;
            valid     <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            out_FRAME <= 1'b0;
            out_SEG   <= SEG_OFF;
            out_AN    <= AN_OFF;
        end else begin
            if (in_DONE) begin
                dig   <= {in_K, in_CEN, in_DEC, in_UND};
                valid <= 1'b1;
            end
            cnt       <= wrap ? '0 : cnt + 1'b1;
            idx       <= wrap ? idx + 2'd1 : idx;
            out_FRAME <= wrap && idx == 2'd3;
            out_SEG   <= seg_hi ^ SEG_OFF;
            out_AN    <= an_hi ^ AN_OFF;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: table vectors, corner sequences and a random run against an arithmetic display model
module tb_bcd_display_scan;
    localparam int DIV = 8;
    localparam int BLK = 2;
    typedef struct packed {
        logic [15:0] dig;
        logic [27:0] seg;
        logic [15:0] an;
    } vec_t;
    const logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_UND = '0, in_DEC = '0, in_CEN = '0, in_K = '0;
    logic       in_DONE = 1'b0;
    logic [6:0] out_SEG, seg2;
    logic [3:0] out_AN, an2;
    logic       out_FRAME, frame2;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 1'b0;
    int unsigned m_t;
    logic [15:0] m_dig;
    logic        m_valid;
    logic [10:0] e1, e2;
    logic        ef;
    vec_t        vecs [7];
    bcd_display_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_BLANK(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .in_UND(in_UND), .in_DEC(in_DEC), .in_CEN(in_CEN), .in_K(in_K),
        .in_DONE(in_DONE), .out_SEG(out_SEG), .out_AN(out_AN), .out_FRAME(out_FRAME));
    bcd_display_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LZ_BLANK(1'b0),
                       .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_UND(in_UND), .in_DEC(in_DEC), .in_CEN(in_CEN), .in_K(in_K),
        .in_DONE(in_DONE), .out_SEG(seg2), .out_AN(an2), .out_FRAME(frame2));
    always #5 clk = ~clk;
    // display content for one time slot: a zero digit is dark when it and every more-significant digit are zero
    function automatic logic [10:0] mdl(input bit lz, input bit sal, input bit aal, input logic [15:0] dg,
                                        input logic v, input int pos, input int slot);
        logic [3:0] val;
        logic [6:0] seg;
        logic [3:0] an;
        bit lit, allz;
        val = dg[slot*4 +: 4];
        lit = v && pos >= BLK;
        if (lz && slot > 0) begin
            allz = 1'b1;
            for (int j = slot; j < 4; j++) if (dg[j*4 +: 4] != 4'd0) allz = 1'b0;
            if (allz) lit = 1'b0;
        end
        seg = !lit ? 7'h00 : val < 4'd10 ? SEG_TAB[val] : 7'h40;
        an = lit ? 4'(1 << slot) : 4'h0;
        return {an ^ {4{aal}}, seg ^ {7{sal}}};
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            m_t     <= 0;
            m_valid <= 1'b0;
            m_dig   <= '0;
            e1      <= mdl(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 0, 0);
            e2      <= mdl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 0);
            ef      <= 1'b0;
        end else begin
            e1  <= mdl(1'b1, 1'b1, 1'b1, m_dig, m_valid, int'(m_t % DIV), int'((m_t / DIV) % 4));
            e2  <= mdl(1'b0, 1'b0, 1'b0, m_dig, m_valid, int'(m_t % DIV), int'((m_t / DIV) % 4));
            ef  <= (m_t % (4 * DIV)) == 4 * DIV - 1;
            m_t <= m_t + 1;
            if (in_DONE) begin
                m_dig   <= {in_K, in_CEN, in_DEC, in_UND};
                m_valid <= 1'b1;
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_seg", 32'(out_SEG), 32'(e1[6:0]));
            chk("model_an", 32'(out_AN), 32'(e1[10:7]));
            chk("model_frame", 32'(out_FRAME), 32'(ef));
            chk("model_seg_nolz", 32'(seg2), 32'(e2[6:0]));
            chk("model_an_nolz", 32'(an2), 32'(e2[10:7]));
            chk("model_frame_nolz", 32'(frame2), 32'(ef));
        end
    end
    task automatic capture(input logic [15:0] dg);
        @(negedge clk);
        {in_K, in_CEN, in_DEC, in_UND} = dg;
        in_DONE = 1'b1;
        @(negedge clk);
        in_DONE = 1'b0;
    endtask
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4 * DIV + 8; n++) begin
            @(negedge clk);
            if (out_FRAME === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no frame pulse, required one within %0d cycles", 4 * DIV + 8);
        end
    endtask
    initial begin
        bit ok;
        int cur, tgt, n;
        vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 16'h7BDE};
        vecs[1] = '{16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 16'hFFFE};
        vecs[2] = '{16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40}, 16'hFFDE};
        vecs[3] = '{16'h000C, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 16'hFFFE};
        vecs[4] = '{16'hA000, {7'h3F, 7'h40, 7'h40, 7'h40}, 16'h7BDE};
        vecs[5] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE};
        vecs[6] = '{16'h9865, {7'h10, 7'h00, 7'h02, 7'h12}, 16'h7BDE};
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_an", 32'(out_AN), 32'hF);
        chk("reset_seg", 32'(out_SEG), 32'h7F);
        chk("reset_frame", 32'(out_FRAME), 32'h0);
        rst = 1'b0;
        wait_frame(ok);
        if (ok) begin
            n = 0;
            for (int i = 1; i <= 4 * DIV + 8; i++) begin
                @(negedge clk);
                chk("idle_an", 32'(out_AN), 32'hF);
                if (out_FRAME === 1'b1) begin
                    n = i;
                    break;
                end
            end
            chk("frame_period", 32'(n), 32'(4 * DIV));
        end
        for (int v = 0; v < 7; v++) begin
            capture(vecs[v].dig);
            wait_frame(ok);
            if (ok) begin
                cur = 0;
                for (int i = 0; i < 4; i++) begin
                    for (int p = 1; p <= 4; p += 3) begin
                        tgt = DIV * i + p + 1;
                        repeat (tgt - cur) @(negedge clk);
                        cur = tgt;
                        chk($sformatf("vec%0d_slot%0d_an", v, i), 32'(out_AN),
                            p < BLK ? 32'hF : 32'(vecs[v].an[4*i +: 4]));
                        chk($sformatf("vec%0d_slot%0d_seg", v, i), 32'(out_SEG),
                            p < BLK ? 32'h7F : 32'(vecs[v].seg[7*i +: 7]));
                    end
                end
            end
        end
        capture(16'h1234);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_an", 32'(out_AN), 32'hF);
        chk("midreset_seg", 32'(out_SEG), 32'h7F);
        chk("midreset_frame", 32'(out_FRAME), 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("dark_after_reset", 32'(out_AN), 32'hF);
        end
        @(negedge clk);
        {in_K, in_CEN, in_DEC, in_UND} = 16'h1111;
        in_DONE = 1'b1;
        @(negedge clk);
        {in_K, in_CEN, in_DEC, in_UND} = 16'h2222;
        @(negedge clk);
        {in_K, in_CEN, in_DEC, in_UND} = 16'h7896;
        @(negedge clk);
        in_DONE = 1'b0;
        wait_frame(ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            chk("held_done_an", 32'(out_AN), 32'hE);
            chk("held_done_seg", 32'(out_SEG), 32'h02);
        end
        @(negedge clk);
        rst = 1'b1;
        in_DONE = 1'b1;
        {in_K, in_CEN, in_DEC, in_UND} = 16'h5555;
        @(negedge clk);
        rst = 1'b0;
        in_DONE = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("done_with_rst_dark", 32'(out_AN), 32'hF);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 299) == 0;
            in_DONE = $urandom_range(0, 29) == 0;
            in_UND = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
            in_DEC = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
            in_CEN = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
            in_K = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0;
        in_DONE = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the BCD converter.
- Captures the four BCD digits (UND, DEC, CEN, K) when the converter pulses DONE.
- Time-multiplexes the captured digits onto a 4-digit common-anode/cathode 7-segment display, with anti-ghosting blanking and optional leading-zero suppression.
- Sits between the BCD converter and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (min 4).
- BLANK_CYCLES, 4, cycles at start of each slot with all anodes off (must be < REFRESH_DIV).
- LZ_BLANK, 1, 1 = suppress leading zeros on K/CEN/DEC; 0 = show all digits.
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (0 lights segment).
- AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (0 enables digit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_UND  in  4  units BCD digit from converter
- in_DEC  in  4  tens BCD digit
- in_CEN  in  4  hundreds BCD digit
- in_K  in  4  thousands BCD digit
- in_DONE  in  1  converter done strobe; digits valid while high
- out_SEG  out  7  segments {g,f,e,d,c,b,a}
- out_AN  out  4  digit enables; an[0]=UND, an[1]=DEC, an[2]=CEN, an[3]=K
- out_FRAME  out  1  one-cycle pulse when scan wraps digit 3 -> 0

Behaviour:
- Reset (rst=1 at posedge):
  - digit regs=0, valid=0, cnt=0, idx=0, out_FRAME=0.
  - out_SEG = all segments off (0x7F if SEG_ACTIVE_LOW else 0x00).
  - out_AN = all off (0xF if AN_ACTIVE_LOW else 0x0).
  - rst has priority over in_DONE in the same cycle.
- Capture: on any posedge with in_DONE=1, all four digit regs load simultaneously and valid<=1. If DONE is held high, regs reload every cycle. No partial capture.
- Scan counter:
  - cnt increments every cycle.
  - When cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1 (mod 4).
  - out_FRAME<=1 for exactly one cycle on the same edge where idx goes 3->0.
  - Scan runs continuously regardless of valid.
- Output stage: out_SEG/out_AN are registered and reflect cnt/idx/digit regs from the previous cycle (1-cycle latency).
  - Anode idx is enabled iff valid=1, cnt>=BLANK_CYCLES, and the digit is not blanked. Otherwise all anodes are off and segments are off.
- Leading-zero suppression (LZ_BLANK=1):
  - K blanked if K==0.
  - CEN blanked if K==0 and CEN==0.
  - DEC blanked if K, CEN, DEC all 0.
  - UND is never blanked (value 0 shows "0").
- Encoding, active-high before polarity inversion: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Any value 10..15 shows dash 0x40 and is never LZ-blanked.
- Polarity: inversion is applied after encoding, at the register input.
- Capture vs. slot: a capture mid-slot changes the displayed segments on the next cycle; the slot timing is unaffected.

Test Plan:
1. REFRESH_DIV=8, BLANK_CYCLES=2, active-low both. Release rst with no DONE -> out_AN=F, out_SEG=7F indefinitely; out_FRAME pulses every 32 cycles.
2. Pulse DONE with K=1,CEN=2,DEC=3,UND=4 -> per slot, after 2 blank cycles, AN=E/SEG=19, AN=D/SEG=30, AN=B/SEG=24, AN=7/SEG=79 (in idx order), each for 6 cycles.
3. LZ_BLANK=1, capture 0,0,0,7 (K..UND) -> only an[0] ever asserts, SEG=78; slots 1-3 fully dark. Capture 0,0,5,0 -> an[1] shows 5 (SEG=12), an[0] shows 0 (SEG=40).
4. Capture UND=0xC -> an[0] slot SEG=3F (dash, active-low); K=0xA with LZ_BLANK=1 -> K shows dash, and lower zeros also shown.
5. Assert rst mid-slot while displaying 1234 -> next cycle AN=F, SEG=7F, cnt/idx=0; display stays dark after release until the next DONE.
6. DONE held high 3 cycles with values changing each cycle -> the last value is displayed; a DONE coincident with rst is ignored (valid stays 0).
